// File: rtl/spi_slave_regs.sv
// SPI slave (mode 3, 16-bit header + 8-bit data) fronting a 15-byte register bank plus one status byte.
// Writes commit one clk_i cycle after the last data bit; CS rising mid-frame aborts and is counted.
module spi_slave_regs #(
    parameter logic [127:0] RST_VAL = 128'h0
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         spi_cs_i,
    input  logic         spi_clk_i,
    input  logic         spi_mosi_i,
    output logic         spi_miso_o,
    output logic         spi_miso_t,
    input  logic [7:0]   sts_i,
    output logic [127:0] reg_o,
    output logic         wr_stb_o,
    output logic [3:0]   wr_addr_o,
    output logic [7:0]   wr_data_o,
    output logic [7:0]   abort_cnt_o
);

    typedef enum logic [1:0] {IDLE, HDR, DAT, HOLD} state_t;

    state_t        state_q, state_d;
    logic [2:0]    cs_sync, sclk_sync;
    logic [1:0]    mosi_sync;
    logic [1:0]    flush_q;
    logic [3:0]    cnt_q;
    logic [15:0]   hdr_q;
    logic [15:0]   hdr_full;
    logic [7:0]    rx_q, tx_q, rd_byte;
    logic [127:0]  bank_q;
    logic          miso_q, drive_q, pend_q;
    logic          sync_ok, cs_rise, cs_fall, sclk_rise, sclk_fall, mosi_bit;
    logic          abort, hdr_done, dat_done;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cs_sync   <= 3'b111;
            sclk_sync <= 3'b111;
            mosi_sync <= 2'b00;
            flush_q   <= 2'd0;
        end else begin
            cs_sync   <= {cs_sync[1:0], spi_cs_i};
            sclk_sync <= {sclk_sync[1:0], spi_clk_i};
            mosi_sync <= {mosi_sync[0], spi_mosi_i};
            if (flush_q != 2'd3) flush_q <= flush_q + 2'd1;
        end
    end

    // Edges are ignored until the chain holds only real samples, so a CS
    // already low at reset release is not mistaken for a fresh falling edge.
    assign sync_ok   = (flush_q == 2'd3);
    assign cs_rise   = sync_ok &  cs_sync[1]   & ~cs_sync[2];
    assign cs_fall   = sync_ok & ~cs_sync[1]   &  cs_sync[2];
    assign sclk_rise = sync_ok &  sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = sync_ok & ~sclk_sync[1] &  sclk_sync[2];
    assign mosi_bit  = mosi_sync[1];
    assign hdr_full  = {hdr_q[14:0], mosi_bit};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        abort    = 1'b0;
        hdr_done = 1'b0;
        dat_done = 1'b0;
        case (state_q)
            IDLE: if (cs_fall) state_d = HDR;
            HDR: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (sclk_rise && cnt_q == 4'd15) begin
                    state_d  = DAT;
                    hdr_done = 1'b1;
                end
            end
            DAT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (sclk_rise && cnt_q == 4'd7) begin
                    state_d  = HOLD;
                    dat_done = 1'b1;
                end
            end
            HOLD: if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_byte = 8'h00;
        if (hdr_full[14:4] == 11'd0) begin
            if (hdr_full[3:0] == 4'hF) rd_byte = sts_i;
            else                       rd_byte = bank_q[{hdr_full[3:0], 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q   <= 4'd0;
            hdr_q   <= 16'd0;
            rx_q    <= 8'd0;
            tx_q    <= 8'd0;
            miso_q  <= 1'b0;
            drive_q <= 1'b0;
        end else begin
            if (state_d != state_q)
                cnt_q <= 4'd0;
            else if (sclk_rise && (state_q == HDR || state_q == DAT))
                cnt_q <= cnt_q + 4'd1;

            if (state_q == HDR && sclk_rise) hdr_q <= hdr_full;
            if (state_q == DAT && sclk_rise) rx_q  <= {rx_q[6:0], mosi_bit};

            if (hdr_done) tx_q <= rd_byte;

            if (state_d == IDLE) begin
                drive_q <= 1'b0;
                miso_q  <= 1'b0;
            end else if (state_q == DAT && hdr_q[15] && sclk_fall) begin
                drive_q <= 1'b1;
                miso_q  <= tx_q[7];
                tx_q    <= {tx_q[6:0], 1'b0};
            end
        end
    end

    // Commit runs in the cycle after the last bit lands in rx_q; the header
    // is frozen by then since HDR cannot be re-entered that quickly.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pend_q      <= 1'b0;
            wr_stb_o    <= 1'b0;
            wr_addr_o   <= 4'd0;
            wr_data_o   <= 8'd0;
            bank_q      <= {8'h00, RST_VAL[119:0]};
            abort_cnt_o <= 8'd0;
        end else begin
            pend_q   <= dat_done && !hdr_q[15] && hdr_q[14:4] == 11'd0 && hdr_q[3:0] != 4'hF;
            wr_stb_o <= pend_q;
            if (pend_q) begin
                bank_q[{hdr_q[3:0], 3'b000} +: 8] <= rx_q;
                wr_addr_o <= hdr_q[3:0];
                wr_data_o <= rx_q;
            end
            if (abort && abort_cnt_o != 8'hFF) abort_cnt_o <= abort_cnt_o + 8'd1;
        end
    end

    assign reg_o      = bank_q;
    assign spi_miso_t = ~drive_q;
    assign spi_miso_o = drive_q & miso_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: bit-banged SPI master, write/read scoreboards, abort and reset cases.
module tb_spi_slave_regs;

    localparam int CLKP = 10;
    localparam int HALF = 80;
    localparam logic [127:0] RV = 128'hAB0E0D0C0B0A09080706050403020100;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         spi_cs = 1'b1, spi_clk = 1'b1, spi_mosi = 1'b0;
    logic         spi_miso_o, spi_miso_t;
    logic [7:0]   sts = 8'h00;
    logic [127:0] reg_o;
    logic         wr_stb;
    logic [3:0]   wr_addr;
    logic [7:0]   wr_data;
    logic [7:0]   abort_cnt;

    int           n_chk = 0, n_fail = 0, n_stb = 0, n_push = 0;
    int           exp_abort = 0;
    logic [3:0]   exp_waddr = 4'd0;
    logic [7:0]   exp_wdata = 8'd0;
    logic [127:0] exp_reg, rv_v;
    wr_t          wr_q[$];
    logic [7:0]   rd_q[$];

    spi_slave_regs #(.RST_VAL(RV)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .spi_cs_i(spi_cs), .spi_clk_i(spi_clk), .spi_mosi_i(spi_mosi),
        .spi_miso_o(spi_miso_o), .spi_miso_t(spi_miso_t),
        .sts_i(sts), .reg_o(reg_o),
        .wr_stb_o(wr_stb), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .abort_cnt_o(abort_cnt)
    );

    always #(CLKP/2) clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && wr_stb === 1'b1) begin
            n_stb++;
            check("stb_expected", wr_q.size() > 0, 1);
            if (wr_q.size() > 0) begin
                wr_t e;
                e = wr_q.pop_front();
                check("stb_addr", wr_addr, e.addr);
                check("stb_data", wr_data, e.data);
                check("stb_reg", reg_o[{e.addr, 3'b000} +: 8], e.data);
            end
        end
    end

    task automatic xfer(input logic [15:0] h, input logic [7:0] d, input int nbits,
                        input int rst_at, output logic [7:0] rx, output logic t_bad);
        logic b;
        rx = 8'h00;
        t_bad = 1'b0;
        spi_cs = 1'b0;
        #(2*HALF);
        for (int i = 0; i < nbits; i++) begin
            b = (i < 16) ? h[15-i] : (i < 24) ? d[23-i] : 1'b0;
            spi_clk = 1'b0;
            spi_mosi = b;
            #HALF;
            if (i < 16 && spi_miso_t !== 1'b1) t_bad = 1'b1;
            if (i >= 16 && i < 24) rx[23-i] = spi_miso_o;
            spi_clk = 1'b1;
            #HALF;
            if (i == rst_at) begin
                rstn = 1'b0;
                #(3*CLKP);
                rstn = 1'b1;
            end
        end
        #HALF;
        spi_cs = 1'b1;
        #(4*HALF);
    endtask

    task automatic do_write(input logic [15:0] h, input logic [7:0] d, input int nbits);
        logic [7:0] rx;
        logic       t_bad;
        wr_t        e;
        if (!h[15] && h[14:4] == 11'd0 && h[3:0] != 4'hF && nbits >= 24) begin
            e.addr = h[3:0];
            e.data = d;
            wr_q.push_back(e);
            n_push++;
            exp_reg[{e.addr, 3'b000} +: 8] = d;
            exp_waddr = e.addr;
            exp_wdata = d;
        end
        if (nbits < 24 && exp_abort < 255) exp_abort++;
        xfer(h, d, nbits, -1, rx, t_bad);
        check("wr_drain", wr_q.size(), 0);
        check("wr_reg", reg_o, exp_reg);
        check("wr_addr", wr_addr, exp_waddr);
        check("wr_data", wr_data, exp_wdata);
        check("wr_abort", abort_cnt, exp_abort);
        check("wr_tri", spi_miso_t, 1'b1);
    endtask

    task automatic do_read(input logic [15:0] h, input logic [7:0] exp);
        logic [7:0] rx, e;
        logic       t_bad;
        int         stb0;
        stb0 = n_stb;
        rd_q.push_back(exp);
        xfer(h, 8'h00, 24, -1, rx, t_bad);
        e = rd_q.pop_front();
        check("rd_data", rx, e);
        check("rd_hdr_tri", t_bad, 1'b0);
        check("rd_no_stb", n_stb, stb0);
        check("rd_reg", reg_o, exp_reg);
        check("rd_miso_idle", {spi_miso_t, spi_miso_o}, 2'b10);
    endtask

    task automatic reset_model();
        exp_reg = {8'h00, rv_v[119:0]};
        exp_abort = 0;
        exp_waddr = 4'd0;
        exp_wdata = 8'd0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_reg"}, reg_o, exp_reg);
        check({tag, "_stb"}, wr_stb, 1'b0);
        check({tag, "_addr"}, wr_addr, 4'd0);
        check({tag, "_data"}, wr_data, 8'd0);
        check({tag, "_abort"}, abort_cnt, 8'd0);
        check({tag, "_miso"}, {spi_miso_t, spi_miso_o}, 2'b10);
    endtask

    initial begin
        logic [7:0] rx;
        logic       t_bad;
        int         stb0;
        rv_v = RV;
        reset_model();
        #(5*CLKP + 3);
        check_reset("rst");
        rstn = 1'b1;
        #(10*CLKP);

        do_write(16'h0003, 8'hA5, 24);
        do_read(16'h8003, 8'hA5);
        sts = 8'h5C;
        do_read(16'h800F, 8'h5C);
        do_write(16'h000F, 8'hFF, 24);
        do_write(16'h0013, 8'h11, 24);
        do_read(16'h8013, 8'h00);
        do_read(16'h8005, 8'h05);

        do_write(16'h0002, 8'h77, 10);
        do_write(16'h000E, 8'h3C, 24);
        do_read(16'h800E, 8'h3C);
        do_write(16'h0007, 8'h99, 20);
        do_write(16'h0001, 8'h5A, 26);

        for (int k = 0; k < 260; k++) begin
            if (exp_abort < 255) exp_abort++;
            xfer(16'h0000, 8'h00, 0, -1, rx, t_bad);
        end
        check("abort_sat", abort_cnt, 8'hFF);
        check("abort_reg", reg_o, exp_reg);

        stb0 = n_stb;
        xfer(16'h0004, 8'hC3, 24, 19, rx, t_bad);
        reset_model();
        check_reset("midrst");
        check("midrst_nostb", n_stb, stb0);

        do_write(16'h0002, 8'h66, 24);
        do_read(16'h8002, 8'h66);

        check("stb_total", n_stb, n_push);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_regs.md
SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

Interface
REQ-001 SHALL have parameter RST_VAL, default 128'h0, reset value of the 16x8 register bank, with byte n at bits [8n+7:8n].
REQ-002 SHALL have port clk_i, input, 1, system clock.
REQ-003 SHALL have port rstn_i, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port spi_cs_i, input, 1, chip select, active low, asynchronous to clk_i.
REQ-005 SHALL have port spi_clk_i, input, 1, SPI clock, idles high, asynchronous to clk_i.
REQ-006 SHALL have port spi_mosi_i, input, 1, serial data from the master.
REQ-007 SHALL have port spi_miso_o, output, 1, serial data to the master.
REQ-008 SHALL have port spi_miso_t, output, 1, MISO tristate control: 1 = high-Z, 0 = driven.
REQ-009 SHALL have port sts_i, input, 8, read-only status value returned at address 0xF.
REQ-010 SHALL have port reg_o, output, 128, register bank contents for addresses 0x0 to 0xE, with byte 15 tied to 0.
REQ-011 SHALL have port wr_stb_o, output, 1, one-cycle pulse on each committed write.
REQ-012 SHALL have port wr_addr_o, output, 4, address of the last committed write.
REQ-013 SHALL have port wr_data_o, output, 8, data of the last committed write.
REQ-014 SHALL have port abort_cnt_o, output, 8, saturating count of aborted frames.

Function
REQ-015 SHALL synchronise spi_cs_i, spi_clk_i and spi_mosi_i through two flops each, then detect SCLK rising and falling edges with a third flop.
REQ-016 SHALL support clk_i frequencies of at least 8x the SCLK frequency; behaviour at lower ratios is unspecified.
REQ-017 SHALL use the frame format: 16-bit header then 8-bit data, MSB first, sampled on SCLK rising edges, with MISO changing on SCLK falling edges.
REQ-018 SHALL decode the header as: bit15 = R/W (1 = read, 0 = write), bits[14:4] = 0 for a valid address, bits[3:0] = register index.
REQ-019 SHALL implement a state machine with states IDLE, HDR, DAT and HOLD.
REQ-020 SHALL move IDLE->HDR on synchronised CS falling; SCLK edges in IDLE SHALL be ignored.
REQ-021 SHALL move HDR->DAT after the 16th sampled rising edge; on that transition a read frame SHALL load the 8-bit transmit shift register with the selected register (sts_i for 0xF, 0x00 for an invalid address).
REQ-022 SHALL move DAT->HOLD after the 8th data rising edge, then HOLD->IDLE on CS rising; extra SCLK edges in HOLD SHALL be ignored and SHALL NOT commit anything.
REQ-023 SHALL commit a write frame to a valid address 0x0 to 0xE one clk_i cycle after detecting the 24th rising edge: update reg_o, latch wr_addr_o/wr_data_o, and pulse wr_stb_o for exactly one cycle.
REQ-024 SHALL discard writes to 0xF or to an invalid address with no strobe and no change to wr_addr_o/wr_data_o.
REQ-025 SHALL hold spi_miso_t at 0 only in DAT of a read frame, from the first falling edge after entering DAT until CS rising; otherwise spi_miso_t SHALL be 1 and spi_miso_o SHALL be 0.
REQ-026 SHALL present the data MSB on spi_miso_o at the first falling edge in DAT and shift one bit per subsequent falling edge.
REQ-027 SHALL, on CS rising in HDR or DAT, return to IDLE with no commit and increment abort_cnt_o, saturating at 0xFF.
REQ-028 SHALL, on CS falling seen in HOLD or in the same cycle as CS rising, be handled as CS rising first; a new frame SHALL start only from IDLE.
REQ-029 SHALL NOT let a read frame alter registers or emit wr_stb_o.

Reset
REQ-030 SHALL, while rstn_i = 0, force: state IDLE, bit counter 0, reg_o = RST_VAL with byte 15 = 0, wr_stb_o = 0, wr_addr_o = 0, wr_data_o = 0, abort_cnt_o = 0, spi_miso_t = 1, spi_miso_o = 0, synchronisers = idle levels (CS = 1, SCLK = 1).
REQ-031 SHALL, when reset asserts mid-frame, abandon the frame without commit and without counting an abort; after release, the block SHALL wait for a fresh CS falling.

Verification
REQ-032 SHALL pass: write frame 0x0003 + 0xA5 -> reg_o[31:24] = 0xA5, one wr_stb_o pulse, wr_addr_o = 3, wr_data_o = 0xA5.
REQ-033 SHALL pass: after REQ-032, read frame 0x8003 -> MISO bits 1,0,1,0,0,1,0,1 on the 8 data clocks; spi_miso_t = 1 during the header.
REQ-034 SHALL pass: sts_i = 0x5C, read 0x800F -> 0x5C returned; write 0x000F + 0xFF -> no strobe, reg_o unchanged.
REQ-035 SHALL pass: write 0x0013 + 0x11 -> discarded; read 0x8013 -> 0x00.
REQ-036 SHALL pass: CS raised after 10 header bits -> no commit, abort_cnt_o = 1; the next valid frame works; 256 aborts -> abort_cnt_o = 0xFF.
REQ-037 SHALL pass: rstn_i pulsed low during the data phase of a write -> all outputs at reset values, abort_cnt_o = 0, no strobe.
